write_back_regfile: RTL
=======================

Name: write_back_regfile

Overview:
- Final pipeline stage of the 32-bit RISC core; directly downstream of the memory-access stage.
- Consumes the MA/WB latch contents: control flags, rd, ALU result, load result and PC.
- Selects the write-back value and commits it to the 16 x 32 architectural register file.
- Provides two read ports to operand fetch, a registered forwarding record to earlier stages, and a retired-instruction counter.

Parameters:
- NREGS, 16, number of architectural registers; index width is $clog2(NREGS) = 4.
- XLEN, 32, data width.
- RA_IDX, 15, return-address register written by call.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  MA/WB latch holds a real instruction (0 = bubble).
- iswb  in  1  instruction writes a register.
- isld  in  1  write-back source is the load result.
- iscall  in  1  write-back source is pc_current+4; destination is RA_IDX.
- rd  in  4  destination register (instruction[25:22]).
- pc_current  in  32  PC of the instruction.
- aluresult  in  32  ALU result.
- ldresult  in  32  data read from memory.
- rs1_addr  in  4  read port 1 index.
- rs2_addr  in  4  read port 2 index.
- rs1_data  out  32  read port 1 data.
- rs2_data  out  32  read port 2 data.
- fwd_valid  out  1  registered: a write committed last cycle.
- fwd_rd  out  4  registered destination of that write.
- fwd_data  out  32  registered value of that write.
- retired  out  32  count of committed (valid) instructions.

Behaviour:
- Reset (rst=1, asynchronous, any time):
  - all registers = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0; retired = 0.
  - rst mid-stream discards the in-flight write of that edge; no partial state survives.
- Result mux (combinational), priority iscall > isld > ALU:
  - wdata = pc_current+4 (mod 2^32) if iscall;
  - else ldresult if isld;
  - else aluresult.
- Destination:
  - wdest = RA_IDX if iscall, else rd.
  - iscall with iswb=0 still writes RA_IDX; call always links.
- Commit:
  - we = wb_valid & (iswb | iscall).
  - On posedge clk with we, regs[wdest] <= wdata.
  - Latency: one edge from the latch being presented to architectural visibility.
  - All 16 registers are writable; there is no hardwired zero register.
- Forwarding record: each posedge, fwd_valid <= we, fwd_rd <= wdest, fwd_data <= wdata. When we=0, fwd_valid <= 0 and fwd_rd/fwd_data hold their previous values.
- Retired counter:
  - Increments by 1 on each posedge with wb_valid=1, whether or not it writes (stores and branches count).
  - Wraps 0xFFFFFFFF -> 0.
- Read ports: combinational, regs[rsN_addr]; rs1 and rs2 may address the same register.
- Bubbles: wb_valid=0 means no write, no count, and fwd_valid <= 0 regardless of the other inputs.

Optional Feature:
- Macro: WB_READ_BYPASS_EN.
- Defined: a read port whose address equals wdest while we=1 returns wdata in the same cycle (write-first). This lets decode read a value being committed this cycle without a stall.
- Undefined: read ports return the stored value only (read-before-write). Upstream hazard logic must stall one extra cycle.

Decomposition:
- Shared package, used by the decode/execute/MA stages:
  - XLEN, NREGS, RA_IDX;
  - reg_idx_t (4-bit) and word_t (32-bit) typedefs;
  - wb_src_e enum {WB_ALU, WB_LD, WB_PC4}.
- One sub-module: regfile_2r1w, the 16 x 32 storage with two async read ports and one sync write port with async reset; it also holds the bypass under the macro.
- Source mux, forwarding record and counter stay in the top module.

Test Plan:
- Reset then read: assert rst mid-cycle after writing r3=0x11 -> rs1_data (r3) = 0, retired = 0, fwd_valid = 0 immediately, without waiting for a clock edge.
- ALU write then load write:
  - Stimulus: wb_valid=1, iswb=1, rd=5, aluresult=0xDEADBEEF; next cycle isld=1, rd=6, ldresult=0x1234.
  - Response: r5=0xDEADBEEF, r6=0x1234, retired=2, fwd_rd=6, fwd_data=0x1234.
- Call link: iscall=1, iswb=0, rd=2, pc_current=0xFFFFFFFC -> r15=0x00000000 (wrap), r2 unchanged, fwd_rd=15.
- Bubble and store:
  - wb_valid=0, iswb=1, rd=1 -> r1 unchanged, retired unchanged, fwd_valid=0.
  - Then wb_valid=1, iswb=0 (store) -> retired +1, no register write.
- Same-cycle read of written register: rd=7 write 0x55 with rs1_addr=rs2_addr=7 (prior value 0x0) -> rs1_data = rs2_data = 0x55 with WB_READ_BYPASS_EN defined, 0x0 without; both read 0x55 after the edge.
- Counter wrap: preload retired to 0xFFFFFFFF via 2^32-1 cycles or force, then one valid cycle -> retired = 0.

Source files
------------

// File: rtl/write_back_regfile_pkg.sv
// Shared write-back definitions for the decode/execute/MA/WB stages.
package write_back_regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int IDXW  = $clog2(NREGS);

    typedef logic [IDXW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_idx_t RA_IDX = reg_idx_t'(15);

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LD  = 2'd1,
        WB_PC4 = 2'd2
    } wb_src_e;

    // Call beats load beats ALU.
    function automatic wb_src_e wb_sel(input logic iscall, input logic isld);
        if (iscall)    return WB_PC4;
        else if (isld) return WB_LD;
        else           return WB_ALU;
    endfunction

endpackage

// File: rtl/write_back_regfile_regfile_2r1w.sv
// Architectural register storage: two async read ports, one sync write port.
// WB_READ_BYPASS_EN selects write-first reads; otherwise reads see stored state only.
module regfile_2r1w #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef WB_READ_BYPASS_EN
    // Write-first: decode sees the value being committed this cycle.
    assign rdata1 = (we && (raddr1 == waddr)) ? wdata : mem[raddr1];
    assign rdata2 = (we && (raddr2 == waddr)) ? wdata : mem[raddr2];
`else
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
`endif

endmodule

// File: rtl/write_back_regfile.sv
// Write-back stage: result select, register commit, forwarding record, retire count.
// Optional macro WB_READ_BYPASS_EN enables same-cycle write-first reads in the regfile.
module write_back_regfile
    import write_back_regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wb_valid,
    input  logic     iswb,
    input  logic     isld,
    input  logic     iscall,
    input  reg_idx_t rd,
    input  word_t    pc_current,
    input  word_t    aluresult,
    input  word_t    ldresult,
    input  reg_idx_t rs1_addr,
    input  reg_idx_t rs2_addr,
    output word_t    rs1_data,
    output word_t    rs2_data,
    output logic     fwd_valid,
    output reg_idx_t fwd_rd,
    output word_t    fwd_data,
    output word_t    retired
);

    wb_src_e  src;
    word_t    wdata;
    reg_idx_t wdest;
    logic     we;

    assign src = wb_sel(iscall, isld);

    always_comb begin
        wdata = aluresult;
        case (src)
            WB_PC4:  wdata = pc_current + word_t'(4);
            WB_LD:   wdata = ldresult;
            default: wdata = aluresult;
        endcase
    end

    // A call always links, even when iswb is clear.
    assign wdest = iscall ? RA_IDX : rd;
    assign we    = wb_valid & (iswb | iscall);

    regfile_2r1w #(
        .DEPTH (NREGS),
        .WIDTH (XLEN)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (wdest),
        .wdata  (wdata),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Address/data only move on a real commit so consumers can ignore them when invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= we;
            if (we) begin
                fwd_rd   <= wdest;
                fwd_data <= wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           retired <= '0;
        else if (wb_valid) retired <= retired + word_t'(1);
    end

endmodule
